// File: rtl/hazard_stall_controller.sv
// Stall/flush generator for the 5-stage RV32I pipeline: load-use, MEM wait, redirect.
// Ports: ID/EX/MEM hazard inputs in; PC/IF-ID/ID-EX/EX-MEM controls, debug, counters out.
module hazard_stall_controller #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             id_is_store,
  input  logic             idex_MemRead,
  input  logic [4:0]       idex_rd,
  input  logic             ex_redirect,
  input  logic             exmem_MemRead,
  input  logic             exmem_MemWrite,
  input  logic             dmem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             mem_wait,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic {
    RUN,
    MEM_WAIT
  } state_t;

  localparam logic [9:0] TimeoutVal = 10'(MEM_TIMEOUT);

  state_t     state;
  state_t     nextState;
  logic [9:0] wdog;
  logic       loadUse;
  logic       memBusy;

  // Store data (rs2) is forwarded in MEM, so only its address operand stalls.
  always_comb begin
    loadUse = idex_MemRead && (idex_rd != 5'd0) &&
      ((id_use_rs1 && (idex_rd == id_rs1)) ||
       (id_use_rs2 && (idex_rd == id_rs2) && !id_is_store));
    memBusy = (exmem_MemRead || exmem_MemWrite) && !dmem_ready;
  end

  always_comb begin
    nextState = state;
    unique case (state)
      RUN:      if (memBusy) nextState = MEM_WAIT;
      MEM_WAIT: if (!memBusy) nextState = RUN;
      default:  nextState = RUN;
    endcase
  end

  // Freeze dominates; a redirect squashes the stalling ID instruction.
  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    mem_wait    = 1'b0;
    if (rst) begin
      idex_bubble = 1'b1;
    end else begin
      mem_wait = (state == MEM_WAIT);
      if (memBusy) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        exmem_hold = 1'b1;
      end else if (ex_redirect) begin
        ifid_flush  = 1'b1;
        idex_bubble = 1'b1;
      end else if (loadUse) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_bubble = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= RUN;
      wdog            <= '0;
      mem_timeout_err <= 1'b0;
      stall_cycles    <= '0;
      flush_count     <= '0;
    end else begin
      state <= nextState;
      if (state == RUN) begin
        wdog <= '0;
      end else begin
        if (wdog != '1) wdog <= wdog + 10'd1;
        if ((wdog + 10'd1) >= TimeoutVal) mem_timeout_err <= 1'b1;
      end
      if (!pc_write && (stall_cycles != '1))
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (ifid_flush && (flush_count != '1))
        flush_count <= flush_count + CNT_W'(1);
    end
  end

endmodule
